// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
//   FWD_*          : EX operand select encodings
//   shadow_entry_t : per-stage copy of the register tags the controller tracks
//   state_t        : memory-wait FSM states
//   tag_match      : dependency test of a source tag against a shadow entry
package hazard_pkg;

    // Tags are stored zero-extended to this width so the struct stays fixed;
    // the controller supports register address widths up to TAG_W.
    localparam int unsigned TAG_W = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rd;
        logic [TAG_W-1:0] rs1;
        logic [TAG_W-1:0] rs2;
        logic             regwrite;
        logic             is_load;
        logic             is_store;
    } shadow_entry_t;

    typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

    // Register 0 never produces a dependency.
    function automatic logic tag_match(shadow_entry_t e, logic [TAG_W-1:0] src);
        return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src);
    endfunction

endpackage

// File: rtl/hazard_shadow_reg.sv
// One shadow pipeline entry.
//   clk, reset : clock, asynchronous active-high reset
//   hold_i     : keep current contents
//   clear_i    : load an all-zero (invalid) entry; wins over hold_i
//   entry_i    : next entry when advancing
//   entry_o    : current entry
module hazard_shadow_reg
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          hold_i,
    input  logic          clear_i,
    input  shadow_entry_t entry_i,
    output shadow_entry_t entry_o
);

    shadow_entry_t entry_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else if (clear_i) begin
            entry_q <= '0;
        end else if (!hold_i) begin
            entry_q <= entry_i;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/hazard_ctrl_p.sv
// Hazard and forwarding controller for the 5-stage RV32 pipeline.
// Tracks EX/MEM/WB register tags in shadow entries and produces:
//   stall_if/stall_id/stall_ex/stall_mem : per-stage hold
//   flush_id, bubble_ex, bubble_wb       : NOP / bubble insertion
//   fwd_a/fwd_b                          : EX operand forwarding selects
//   byp_id_a/byp_id_b                    : WB-to-ID register file bypass
//   mem_timeout                          : sticky data-memory wait timeout
//   stall_cycles                         : saturating count of stall_if cycles
// Inputs are the ID-stage decode fields, br_taken and mem_ready.
module hazard_ctrl_p
    import hazard_pkg::*;
#(
    parameter int unsigned AW       = 5,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          id_is_load,
    input  logic          id_is_store,
    input  logic          br_taken,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_id,
    output logic          flush_id,
    output logic          stall_ex,
    output logic          bubble_ex,
    output logic          stall_mem,
    output logic          bubble_wb,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          byp_id_a,
    output logic          byp_id_b,
    output logic          mem_timeout,
    output logic [CW-1:0] stall_cycles
);

    localparam int unsigned WCW = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;

    shadow_entry_t se, sm, sw, se_d;
    logic [TAG_W-1:0] rs1_x, rs2_x;
    logic freeze, load_use, sm_mem;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_timeout_q, mem_timeout_d;
    logic [CW-1:0]  stall_cycles_q, stall_cycles_d;
    logic           flush_q, flush_d;

    assign rs1_x = TAG_W'(id_rs1);
    assign rs2_x = TAG_W'(id_rs2);

    assign sm_mem   = sm.valid & (sm.is_load | sm.is_store);
    assign freeze   = sm_mem & ~mem_ready;
    assign load_use = ~freeze & id_valid & se.is_load &
                      (tag_match(se, rs1_x) | tag_match(se, rs2_x));

    // The slot right after a flush holds the squashed instruction.
    always_comb begin
        se_d          = '0;
        se_d.valid    = id_valid & ~flush_q;
        se_d.rd       = TAG_W'(id_rd);
        se_d.rs1      = rs1_x;
        se_d.rs2      = rs2_x;
        se_d.regwrite = id_regwrite;
        se_d.is_load  = id_is_load;
        se_d.is_store = id_is_store;
    end

    hazard_shadow_reg u_se (
        .clk    (clk),
        .reset  (reset),
        .hold_i (freeze),
        .clear_i(load_use),
        .entry_i(se_d),
        .entry_o(se)
    );

    hazard_shadow_reg u_sm (
        .clk    (clk),
        .reset  (reset),
        .hold_i (freeze),
        .clear_i(1'b0),
        .entry_i(se),
        .entry_o(sm)
    );

    // WB drains during a freeze so its write is not repeated.
    hazard_shadow_reg u_sw (
        .clk    (clk),
        .reset  (reset),
        .hold_i (1'b0),
        .clear_i(freeze),
        .entry_i(sm),
        .entry_o(sw)
    );

    assign stall_if  = freeze | load_use;
    assign stall_id  = freeze | load_use;
    assign stall_ex  = freeze;
    assign stall_mem = freeze;
    assign bubble_wb = freeze;
    assign bubble_ex = load_use;
    assign flush_id  = br_taken & ~freeze & ~load_use;

    // Loads in MEM have no data yet; the load-use stall covers them.
    always_comb begin
        fwd_a = FWD_RF;
        if (tag_match(sm, se.rs1) && !sm.is_load) begin
            fwd_a = FWD_MEM;
        end else if (tag_match(sw, se.rs1)) begin
            fwd_a = FWD_WB;
        end
        fwd_b = FWD_RF;
        if (tag_match(sm, se.rs2) && !sm.is_load) begin
            fwd_b = FWD_MEM;
        end else if (tag_match(sw, se.rs2)) begin
            fwd_b = FWD_WB;
        end
    end

    assign byp_id_a = tag_match(sw, rs1_x);
    assign byp_id_b = tag_match(sw, rs2_x);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        unique case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (freeze) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    if (wait_cnt_q != WCW'(MAX_WAIT)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WCW'(MAX_WAIT)) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_if && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // IF_ID is held during a freeze, so the flush marker must be held too.
    assign flush_d = freeze ? flush_q : flush_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_q        <= flush_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p: a default instance and a small one
// (MAX_WAIT=3, CW=2) sharing the same stimulus for saturation/timeout edges.
module tb_hazard_ctrl_p;
    import hazard_pkg::*;

    logic       clk, reset;
    logic       id_valid, id_regwrite, id_is_load, id_is_store, br_taken, mem_ready;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        stall_if, stall_id, flush_id, stall_ex, bubble_ex, stall_mem, bubble_wb;
    logic [1:0]  fwd_a, fwd_b;
    logic        byp_id_a, byp_id_b, mem_timeout;
    logic [15:0] stall_cycles;

    logic        s_stall_if, s_stall_id, s_flush_id, s_stall_ex, s_bubble_ex, s_stall_mem;
    logic        s_bubble_wb, s_byp_id_a, s_byp_id_b, s_mem_timeout;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl_p #(.AW(5), .MAX_WAIT(15), .CW(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_is_store(id_is_store), .br_taken(br_taken), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .stall_mem(stall_mem), .bubble_wb(bubble_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .byp_id_a(byp_id_a), .byp_id_b(byp_id_b),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    hazard_ctrl_p #(.AW(5), .MAX_WAIT(3), .CW(2)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_is_store(id_is_store), .br_taken(br_taken), .mem_ready(mem_ready),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_id(s_flush_id),
        .stall_ex(s_stall_ex), .bubble_ex(s_bubble_ex), .stall_mem(s_stall_mem),
        .bubble_wb(s_bubble_wb), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .byp_id_a(s_byp_id_a), .byp_id_b(s_byp_id_b),
        .mem_timeout(s_mem_timeout), .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic rw, input logic ld,
                         input logic st);
        id_valid    = v;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        id_is_store = st;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        br_taken  = 1'b0;
        mem_ready = 1'b1;
        nop();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        br_taken  = 1'b0;
        mem_ready = 1'b1;
        nop();
        #3;
        check("rst_stall_if", 32'(stall_if), 32'd0);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(RUN));
        tick();
        reset = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); settle();
        check("a_c1_stall", 32'(stall_if), 32'd0);
        tick();
        drive(1, 5'd5, 5'd3, 5'd6, 1, 0, 0); settle();
        check("a_c2_stall", 32'(stall_if), 32'd0);
        tick();
        nop(); settle();
        check("a_fwd_a_mem", 32'(fwd_a), 32'(FWD_MEM));
        check("a_fwd_b_rf", 32'(fwd_b), 32'(FWD_RF));
        check("a_no_stall", 32'(stall_if), 32'd0);
        tick();
        // add x5 now in WB
        drive(1, 5'd5, 5'd7, 5'd0, 0, 0, 0); settle();
        check("a_byp_a", 32'(byp_id_a), 32'd1);
        check("a_byp_b", 32'(byp_id_b), 32'd0);
        tick();
        // add x5 ; add x9 ; sub x6,x5,x3 -> WB forward
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd3, 5'd6, 1, 0, 0); tick();
        nop(); settle();
        check("a_fwd_a_wb", 32'(fwd_a), 32'(FWD_WB));
        check("a_fwd_b_rf2", 32'(fwd_b), 32'(FWD_RF));
        tick();

        // lw x5,0(x1) ; add x6,x5,x5 -> one stall, then WB forward
        do_reset();
        drive(1, 5'd1, 5'd0, 5'd5, 1, 1, 0); tick();
        drive(1, 5'd5, 5'd5, 5'd6, 1, 0, 0); settle();
        check("b_stall_if", 32'(stall_if), 32'd1);
        check("b_stall_id", 32'(stall_id), 32'd1);
        check("b_bubble_ex", 32'(bubble_ex), 32'd1);
        check("b_stall_ex", 32'(stall_ex), 32'd0);
        tick();
        settle();
        check("b_stall_once", 32'(stall_if), 32'd0);
        check("b_bubble_once", 32'(bubble_ex), 32'd0);
        tick();
        nop(); settle();
        check("b_fwd_a", 32'(fwd_a), 32'(FWD_WB));
        check("b_fwd_b", 32'(fwd_b), 32'(FWD_WB));
        check("b_stall_cycles", 32'(stall_cycles), 32'd1);
        tick();

        // lw x0 ; sub x6,x0,x0 -> no dependency through x0
        do_reset();
        drive(1, 5'd1, 5'd0, 5'd0, 1, 1, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd6, 1, 0, 0); settle();
        check("c_no_stall", 32'(stall_if), 32'd0);
        tick();
        nop(); settle();
        check("c_fwd_a", 32'(fwd_a), 32'(FWD_RF));
        check("c_fwd_b", 32'(fwd_b), 32'(FWD_RF));
        tick();

        // Branch flush, then branch colliding with load-use
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd0, 0, 0, 0); br_taken = 1'b1; settle();
        check("d_flush", 32'(flush_id), 32'd1);
        check("d_flush_nostall", 32'(stall_if), 32'd0);
        tick();
        nop(); br_taken = 1'b0; settle();
        check("d_flush_one", 32'(flush_id), 32'd0);
        tick();
        drive(1, 5'd1, 5'd0, 5'd5, 1, 1, 0); tick();
        drive(1, 5'd5, 5'd0, 5'd0, 0, 0, 0); br_taken = 1'b1; settle();
        check("d_lu_flush", 32'(flush_id), 32'd0);
        check("d_lu_stall", 32'(stall_if), 32'd1);
        tick();
        settle();
        check("d_late_flush", 32'(flush_id), 32'd1);
        check("d_late_nostall", 32'(stall_if), 32'd0);
        tick();
        nop(); br_taken = 1'b0;

        // Store in MEM with mem_ready low for 3 cycles
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd0, 0, 0, 1); tick();
        nop(); tick();
        drive(1, 5'd3, 5'd4, 5'd7, 1, 0, 0); br_taken = 1'b1; mem_ready = 1'b0; settle();
        check("e_f0_stall_if", 32'(stall_if), 32'd1);
        check("e_f0_stall_ex", 32'(stall_ex), 32'd1);
        check("e_f0_stall_mem", 32'(stall_mem), 32'd1);
        check("e_f0_bubble_wb", 32'(bubble_wb), 32'd1);
        check("e_f0_flush", 32'(flush_id), 32'd0);
        check("e_f0_bubble_ex", 32'(bubble_ex), 32'd0);
        tick();
        settle();
        check("e_f1_state", 32'(dut.state_q), 32'(MEM_WAIT));
        check("e_f1_stall_mem", 32'(stall_mem), 32'd1);
        tick();
        settle();
        check("e_f2_stall_mem", 32'(stall_mem), 32'd1);
        tick();
        mem_ready = 1'b1; br_taken = 1'b0; settle();
        check("e_resume_stall", 32'(stall_mem), 32'd0);
        check("e_resume_bubble", 32'(bubble_wb), 32'd0);
        check("e_stall_cycles", 32'(stall_cycles), 32'd3);
        tick();
        nop(); settle();
        check("e_state_run", 32'(dut.state_q), 32'(RUN));
        tick();

        // Long wait: timeout after 15 wait cycles, sticky, cleared by reset
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd0, 0, 0, 1); tick();
        nop(); tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            settle();
            check($sformatf("f_timeout_k%0d", k), 32'(mem_timeout), 32'(k >= 16));
            check($sformatf("f_s_timeout_k%0d", k), 32'(s_mem_timeout), 32'(k >= 4));
            if (k == 19) begin
                check("f_frozen", 32'(stall_mem), 32'd1);
                check("f_stall_cycles", 32'(stall_cycles), 32'd19);
                check("f_s_stall_sat", 32'(s_stall_cycles), 32'd3);
            end
            tick();
        end
        settle();
        check("f_sticky", 32'(mem_timeout), 32'd1);
        reset = 1'b1;
        #1;
        check("g_stall_if", 32'(stall_if), 32'd0);
        check("g_stall_mem", 32'(stall_mem), 32'd0);
        check("g_bubble_wb", 32'(bubble_wb), 32'd0);
        check("g_timeout", 32'(mem_timeout), 32'd0);
        check("g_stall_cycles", 32'(stall_cycles), 32'd0);
        check("g_state", 32'(dut.state_q), 32'(RUN));
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
